// File: rtl/phy_types_pkg.sv
// Shared PHY-side types: comma selector for uart_tx frames and the launch
// sequencer state encoding.
package phy_types_pkg;

    localparam int SYMBOL_W = 10;

    typedef enum logic [1:0] {
        NADA                = 2'd0,
        SELECT_COMMA_DATA   = 2'd1,
        SELECT_COMMA_1_FLIT = 2'd2,
        SELECT_COMMA_2_FLIT = 2'd3
    } comma_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } tx_sched_state_t;

    // A request may only be queued if it carries a real selector.
    function automatic logic comma_sel_legal(input comma_sel_t sel);
        return sel != NADA;
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Parameterized synchronous FIFO. Pointers carry one extra wrap bit so full
// and empty are told apart without a separate counter.
module sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; wrap is natural at the power-of-two boundary.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; only slots behind the pointers are ever read.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_sched.sv
// Request queue and launch sequencer in front of uart_tx: buffers frames,
// issues one-cycle start pulses, waits for completion with a watchdog.
module uart_tx_sched
    import phy_types_pkg::*;
#(
    parameter  int PORTCOUNT = 5,
    parameter  int DEPTH     = 4,
    parameter  int TIMEOUT   = 1024,
    localparam int FRAME_W   = PORTCOUNT * SYMBOL_W,
    localparam int OCC_W     = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                nRST,
    // Handshake: a transfer occurs on a rising CLK edge where req_valid and
    // req_ready are both high. req_ready depends only on FIFO fullness, never
    // on req_valid or on a pop in the same cycle; the source must hold its
    // payload stable while req_valid is high and req_ready is low.
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FRAME_W-1:0]  req_data,
    input  comma_sel_t          req_comma_sel,
    output logic                tx_start,
    output logic [FRAME_W-1:0]  tx_data,
    output comma_sel_t          tx_comma_sel,
    input  logic                tx_done,
    output logic [OCC_W-1:0]    occupancy,
    output logic                busy,
    output logic [1:0]          err,
    input  logic                err_clr,
    output tx_sched_state_t     state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    tx_sched_state_t     state, state_n;
    logic [WD_W-1:0]     wd, wd_n;
    logic                start_n;
    logic [FRAME_W-1:0]  data_n;
    comma_sel_t          sel_n;
    logic [1:0]          err_n;
    logic                timeout_evt;

    logic                handshake;
    logic                fifo_push;
    logic                fifo_pop;
    logic                illegal_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FRAME_W+1:0]  fifo_rdata;
    comma_sel_t          head_sel;
    logic [FRAME_W-1:0]  head_data;

    assign handshake   = req_valid && req_ready;
    assign fifo_push   = handshake && comma_sel_legal(req_comma_sel);
    assign illegal_req = handshake && !comma_sel_legal(req_comma_sel);
    assign req_ready   = !fifo_full;

    sched_fifo #(
        .WIDTH (FRAME_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_comma_sel, req_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign head_sel  = comma_sel_t'(fifo_rdata[FRAME_W +: 2]);
    assign head_data = fifo_rdata[FRAME_W-1:0];

    // Next-state, pop request, next launch outputs and watchdog.
    always_comb begin
        state_n     = state;
        fifo_pop    = 1'b0;
        start_n     = 1'b0;
        data_n      = '0;
        sel_n       = NADA;
        wd_n        = wd;
        timeout_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    start_n  = 1'b1;
                    data_n   = head_data;
                    sel_n    = head_sel;
                    state_n  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_n    = WD_W'(TIMEOUT - 1);
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over an expiring watchdog.
                if (tx_done) begin
                    state_n = ST_GAP;
                end else if (wd == '0) begin
                    timeout_evt = 1'b1;
                    state_n     = ST_GAP;
                end else begin
                    wd_n = wd - 1'b1;
                end
            end
            ST_GAP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Sticky error flags; a new event in the clear cycle wins.
    always_comb begin
        err_n    = err;
        err_n[0] = illegal_req || (err[0] && !err_clr);
        err_n[1] = timeout_evt || (err[1] && !err_clr);
    end

    // State, watchdog, registered launch outputs and error flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= ST_IDLE;
            wd           <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            tx_comma_sel <= NADA;
            err          <= '0;
        end else begin
            state        <= state_n;
            wd           <= wd_n;
            tx_start     <= start_n;
            tx_data      <= data_n;
            tx_comma_sel <= sel_n;
            err          <= err_n;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Request queue and launch sequencer in front of `uart_tx`.
- Accepts frames (PORTCOUNT 10-bit symbols plus a comma selector) from the link layer over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues each frame to `uart_tx` as a single-cycle `start` pulse, then holds off until `uart_tx` reports completion.
- Turns `uart_tx`'s one-shot start interface into a back-pressured stream, with a watchdog on the transmitter.

## Interface
Parameters:
- PORTCOUNT, 5, symbols per frame; frame width FRAME_W = PORTCOUNT*10
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 1024, cycles allowed between `tx_start` and `tx_done`

Ports:
- CLK  in  1  clock; single clock domain
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  space available; a transfer happens when valid and ready are both high
- req_data  in  FRAME_W  frame symbols; [FRAME_W-1 -: 10] is sent first
- req_comma_sel  in  comma_sel_t  SELECT_COMMA_DATA, SELECT_COMMA_1_FLIT, SELECT_COMMA_2_FLIT; NADA is illegal
- tx_start  out  1  one-cycle launch pulse to uart_tx
- tx_data  out  FRAME_W  frame during the start cycle, otherwise 0
- tx_comma_sel  out  comma_sel_t  selector during the start cycle, otherwise NADA
- tx_done  in  1  one-cycle pulse from uart_tx once the last stop bit has been sent
- occupancy  out  $clog2(DEPTH)+1  FIFO entries held
- busy  out  1  FSM not in IDLE
- err  out  2  sticky flags: [0] illegal request dropped, [1] timeout
- err_clr  in  1  clears `err`

## Operation
- **FIFO:** circular buffer with `rd_ptr`/`wr_ptr` of width $clog2(DEPTH)+1; the MSB distinguishes full from empty; the pointers wrap naturally.
  - `req_ready = !full`. Ready is independent of a pop in the same cycle; there is no bypass.
- **Illegal requests:** a handshake with `req_comma_sel == NADA` is consumed but not written, and sets `err[0]`.
- **FSM** (state type `tx_sched_state_t`):
  - IDLE: if the FIFO is non-empty, pop the head and register `tx_start=1`, `tx_data`, `tx_comma_sel`; go to LAUNCH.
  - LAUNCH: the start pulse is visible this cycle; load the watchdog counter with TIMEOUT-1; go to WAIT.
  - WAIT: on `tx_done`, go to GAP. If the counter reaches 0 first, set `err[1]` and go to GAP. Otherwise decrement.
  - GAP: one idle cycle that guarantees `uart_tx` sees start low; go to IDLE.
- `tx_done` outside WAIT is ignored.
- `tx_done` and counter==0 in the same cycle count as done; `err[1]` is not set.
- **Error flags:**
  - `err_clr` and a new error event in the same cycle: the set wins.
  - `err` bits stay set until `err_clr` is asserted.
- **Occupancy:** on a simultaneous push and pop, `occupancy` is unchanged.

## Timing
- **Reset values:** every output is 0 (`tx_comma_sel`=NADA), with `req_ready`=1 and FSM=IDLE. Reset empties the FIFO and takes effect immediately, including mid-WAIT; any frame in flight is abandoned.
- **Launch latency:** a request accepted at edge N, into an empty FIFO with FSM in IDLE, produces `tx_start` high for exactly the cycle following edge N+1.
- **Frame spacing:** minimum spacing between consecutive `tx_start` pulses is completion + 2 cycles. `tx_done` at edge D → next `tx_start` high after edge D+2.
- **Output registers:** `tx_start`, `tx_data` and `tx_comma_sel` are registered outputs with no combinational path from any input.
- **Status timing:** `occupancy`, `busy` and `err` are registered and update on the edge that causes the change.
- **Full-FIFO throughput:** while full, a push is accepted in the cycle after a pop, so DEPTH frames keep the transmitter back-to-back.

## Structure
- `tx_sched_state_t` belongs in `phy_types_pkg`, next to the existing `comma_sel_t`.
- FRAME_W is derived locally.
- One sub-module, `sched_fifo`, a parameterized synchronous FIFO:
  - inputs: push, pop, wdata;
  - outputs: rdata, full, empty, count.
- The FSM and watchdog are in the top.

## Test plan
- **Reset:** assert nRST=0 mid-WAIT with 3 entries queued → all outputs go to reset values; occupancy=0; no `tx_start` after release until a new request arrives.
- **Single frame:** push {10'h354,10'h2AB,10'h3C3,10'h0F0,10'h333} as DATA. `tx_done` (driven by a uart_tx instance at CLKDIV_COUNT=10) arrives 121 cycles after start.
  - Required: `tx_start` 2 cycles after acceptance, `tx_data` exact, `tx_data`=0 on all other cycles, busy returns to 0 after GAP.
- **Back-pressure:** push 6 frames back-to-back with DEPTH=4.
  - `req_ready` drops after 5 acceptances (one frame popped to LAUNCH).
  - All frames reach `uart_rx` in order with correct data.
- **Mixed commas:** queue DATA, then 2-flit comma {10'h157,10'h2F5,30'h1}, then 1-flit comma {10'h2D7,10'h3C1,30'h1}.
  - Each `tx_comma_sel` matches its request.
  - `uart_rx` receives data[19:0]=req[49:30] for the 2-flit comma and data[9:0]=req[49:40] for the 1-flit comma.
- **Illegal request:** push with comma_sel=NADA → accepted, occupancy unchanged, `err[0]`=1; after `err_clr`, `err`=0.
- **Timeout:** TIMEOUT=16 with `tx_done` never asserted.
  - `err[1]` sets on the 16th cycle after LAUNCH; FSM passes through GAP and launches the next queued frame.
  - A late stray `tx_done` in IDLE is ignored.
